fdiv_prog_nch: RTL and testbench
================================

// Module: fdiv_prog_nch
// PURPOSE
//  N_CH-channel programmable clock divider / tick generator for the display and timing subsystem.
//  Each channel divides clk_in by a run-time divisor D.
//  Each channel outputs a one-cycle tick per period, plus a mode-selected clk_out (tick or ~50% square).
//  Divisor changes are shadowed and take effect only at a period boundary, so the outputs never glitch.
// PARAMETERS
//  N_CH        2     number of independent divider channels
//  CNT_W       16    counter/divisor width per channel
//  DEFAULT_DIV 1000  divisor loaded into every channel at reset (must fit CNT_W)
// PORTS
//  clk_in   in   1            system clock, all logic on posedge
//  rst_n    in   1            asynchronous active-low reset
//  en       in   N_CH         per-channel run enable
//  mode     in   N_CH         per-channel clk_out select: 0 = tick, 1 = square
//  div_ld   in   N_CH         per-channel divisor load strobe (1 cycle)
//  div_in   in   N_CH*CNT_W   packed divisors; channel k uses div_in[k*CNT_W +: CNT_W]
//  tick     out  N_CH         registered 1-cycle pulse, once per D enabled cycles
//  clk_out  out  N_CH         registered; mode 0 = tick, mode 1 = square wave
// BEHAVIOUR
//  - Reset (async, rst_n=0): cnt=0, act_div=shadow=DEFAULT_DIV, pend=0, tick=0, clk_out=0. Same behaviour mid-period.
//  - Effective divisor: D = (act_div==0) ? 1 : act_div. Period is exactly D clk_in cycles.
//  - en=1 edge, cnt==D-1 (wrap): cnt<=0, tick<=1.
//  - en=1 edge, otherwise: cnt<=cnt+1, tick<=0.
//  - First tick is high on the D-th enabled edge after cnt=0. D=1 gives tick constantly high.
//  - Square output: sq<=(cnt_next < ceil(D/2)), where cnt_next is the value cnt takes this edge.
//    The high phase starts in the tick cycle. High ceil(D/2) cycles, low floor(D/2). D=1 gives constant high.
//  - clk_out<=mode ? sq : tick_next. A mode change takes effect on the next edge; no count disturbance.
//  - en=0 edge: cnt<=0, tick<=0, clk_out<=0 (one-cycle latency).
//    Re-enable restarts the period from 0; first tick after D edges.
//  - div_ld=1, en=1: shadow<=div_in slice, pend<=1. At the next wrap: act_div<=shadow, pend<=0.
//    The new period begins immediately after that wrap.
//  - div_ld on the same edge as a wrap: the new value bypasses the shadow and is applied at this wrap.
//  - div_ld while en=0: act_div loads directly.
//  - Repeated div_ld before a wrap: the last value wins.
//  - The current period always completes with the old D, even if the new D is less than or equal to cnt. No truncation, no glitch.
//  - Channels are fully independent. No combinational path from inputs to outputs.
// CONFIGURATION
//  FDIV_TICKCNT_EN defined: adds output tick_cnt [N_CH*8-1:0].
//    Per-channel 8-bit count of ticks, wraps 255->0.
//    Reset 0; cleared while en=0; increments on the edge where tick goes high.
//  FDIV_TICKCNT_EN undefined: the port and its counters do not exist. All other behaviour is identical.
// TESTING
//  1 Reset, en=1, mode=0, D=1000 -> tick pulses at edges 1000, 2000, 3000. Each pulse is exactly 1 cycle.
//  2 D=5, mode=1 -> clk_out pattern 1,1,1,0,0 repeating. D=4 -> 1,1,0,0. D=1 and D=0 -> constant 1.
//  3 D=10, div_ld to 3 at cnt=7 -> ticks at 10, 13, 16. Same load at cnt=9 (wrap edge) -> ticks at 10, 13.
//  4 en drops at cnt=4 (D=10) -> tick/clk_out=0 next cycle. Re-enable -> first tick 10 edges later.
//  5 rst_n pulsed low mid-period, asynchronously between edges -> all outputs 0 immediately.
//    After release, D=DEFAULT_DIV. Ch0 D=3 and ch1 D=7 run concurrently without interaction.
//  6 FDIV_TICKCNT_EN defined, D=2, 600 cycles -> tick_cnt wraps to 44. Build without the macro lints clean.

Source files
------------

// File: rtl/fdiv_prog_nch_if.sv
// rtl/fdiv_prog_nch_if.sv - control/output bundle for the N_CH programmable divider
// Optional tick_cnt signal exists only when FDIV_TICKCNT_EN is defined.
interface fdiv_prog_nch_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       mode;
  logic [N_CH-1:0]       div_ld;
  logic [N_CH*CNT_W-1:0] div_in;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       clk_out;
`ifdef FDIV_TICKCNT_EN
  logic [N_CH*8-1:0]     tick_cnt;
`endif

  modport master (
    output en, mode, div_ld, div_in,
    input  tick, clk_out
`ifdef FDIV_TICKCNT_EN
    , input tick_cnt
`endif
  );

  modport slave (
    input  en, mode, div_ld, div_in,
    output tick, clk_out
`ifdef FDIV_TICKCNT_EN
    , output tick_cnt
`endif
  );
endinterface

// File: rtl/fdiv_prog_nch.sv
// rtl/fdiv_prog_nch.sv - N_CH programmable clock divider with shadowed divisors
// Define FDIV_TICKCNT_EN to add per-channel 8-bit tick counters on bus.tick_cnt.
module fdiv_prog_nch #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input logic            clk_in,
  input logic            rst_n,
  fdiv_prog_nch_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [CNT_W-1:0] act_div_q [N_CH];
  logic [CNT_W-1:0] act_div_d [N_CH];
  logic [CNT_W-1:0] shadow_q  [N_CH];
  logic [CNT_W-1:0] shadow_d  [N_CH];
  logic [CNT_W-1:0] d_eff     [N_CH];
  logic [CNT_W-1:0] ld_val    [N_CH];
  logic [CNT_W:0]   half      [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  sq;

`ifdef FDIV_TICKCNT_EN
  logic [7:0] tcnt_q [N_CH];
  logic [7:0] tcnt_d [N_CH];
`endif

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cnt_d[k]     = cnt_q[k];
      act_div_d[k] = act_div_q[k];
      shadow_d[k]  = shadow_q[k];
      pend_d[k]    = pend_q[k];
      tick_d[k]    = 1'b0;
      clk_d[k]     = 1'b0;
      ld_val[k]    = bus.div_in[k*CNT_W +: CNT_W];
      // A zero divisor behaves as divide-by-one.
      d_eff[k]     = (act_div_q[k] == '0) ? ONE : act_div_q[k];
      half[k]      = ({1'b0, d_eff[k]} + ONE_X) >> 1;
      wrap[k]      = bus.en[k] && (cnt_q[k] == d_eff[k] - ONE);
      sq[k]        = 1'b0;

      if (!bus.en[k]) begin
        cnt_d[k] = '0;
        if (bus.div_ld[k]) begin
          act_div_d[k] = ld_val[k];
          shadow_d[k]  = ld_val[k];
          pend_d[k]    = 1'b0;
        end
      end else begin
        if (wrap[k]) begin
          cnt_d[k]  = '0;
          tick_d[k] = 1'b1;
          // A load on the wrap edge bypasses the shadow.
          if (bus.div_ld[k]) begin
            act_div_d[k] = ld_val[k];
            shadow_d[k]  = ld_val[k];
            pend_d[k]    = 1'b0;
          end else if (pend_q[k]) begin
            act_div_d[k] = shadow_q[k];
            pend_d[k]    = 1'b0;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + ONE;
          if (bus.div_ld[k]) begin
            shadow_d[k] = ld_val[k];
            pend_d[k]   = 1'b1;
          end
        end
        // Square phase uses the divisor of the period being counted.
        sq[k]    = ({1'b0, cnt_d[k]} < half[k]);
        clk_d[k] = bus.mode[k] ? sq[k] : tick_d[k];
      end
    end
  end

`ifdef FDIV_TICKCNT_EN
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      tcnt_d[k] = tcnt_q[k];
      if (!bus.en[k]) begin
        tcnt_d[k] = '0;
      end else if (tick_d[k]) begin
        tcnt_d[k] = tcnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) tcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) tcnt_q[k] <= tcnt_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) bus.tick_cnt[k*8 +: 8] = tcnt_q[k];
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k]     <= '0;
        act_div_q[k] <= DEF_DIV;
        shadow_q[k]  <= DEF_DIV;
      end
      pend_q <= '0;
      tick_q <= '0;
      clk_q  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k]     <= cnt_d[k];
        act_div_q[k] <= act_div_d[k];
        shadow_q[k]  <= shadow_d[k];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clk_out = clk_q;

endmodule

// File: tb/tb_fdiv_prog_nch.sv
// tb/tb_fdiv_prog_nch.sv - scoreboard bench for fdiv_prog_nch
// Stimulus pushes expected tick times and output levels; a negedge monitor pops and compares.
module tb_fdiv_prog_nch;
  localparam int N_CH  = 2;
  localparam int CNT_W = 16;
  localparam int DEF   = 1000;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  fdiv_prog_nch_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  fdiv_prog_nch #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    bit is_clk;
    bit val;
  } samp_t;

  samp_t samp_q[$];
  int    tq0[$];
  int    tq1[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick_seen(input int ch);
    int sz;
    sz = (ch == 0) ? tq0.size() : tq1.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick%0d_unexpected: got tick at cycle %0d expected none", ch, cyc);
    end else if (ch == 0) begin
      check("tick0_time", cyc, tq0.pop_front());
    end else begin
      check("tick1_time", cyc, tq1.pop_front());
    end
  endtask

  // Monitor: every observed tick must match the next expected time; levels checked at their cycle.
  always @(negedge clk_in) begin
    samp_t s;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.tick[c] === 1'b1) tick_seen(c);
    end
    while (samp_q.size() > 0 && samp_q[0].cyc == cyc) begin
      s = samp_q.pop_front();
      if (s.is_clk) check($sformatf("clk_out%0d_level", s.ch), bus.clk_out[s.ch], s.val);
      else          check($sformatf("tick%0d_level", s.ch), bus.tick[s.ch], s.val);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_samp(input int c, input int ch, input bit is_clk, input bit val);
    samp_q.push_back('{c, ch, is_clk, val});
  endtask

  task automatic push_tick(input int ch, input int c);
    if (ch == 0) tq0.push_back(c);
    else         tq1.push_back(c);
  endtask

  task automatic load_idle(input int ch, input int v);
    bus.div_ld[ch] = 1'b1;
    bus.div_in[ch*CNT_W +: CNT_W] = CNT_W'(v);
    step(1);
    bus.div_ld[ch] = 1'b0;
  endtask

  // Enable one channel for n cycles; pat[i] is the square level when k % deff == i.
  task automatic run_ch(input int ch, input int v, input int deff, input bit md,
                        input bit [7:0] pat, input int n);
    int base;
    load_idle(ch, v);
    bus.mode[ch] = md;
    bus.en[ch]   = 1'b1;
    base = cyc;
    for (int k = 1; k <= n; k++) begin
      if (k % deff == 0) push_tick(ch, base + k);
      if (md) push_samp(base + k, ch, 1'b1, pat[k % deff]);
      else    push_samp(base + k, ch, 1'b1, (k % deff) == 0);
    end
    step(n);
    bus.en[ch] = 1'b0;
    push_samp(base + n + 1, ch, 1'b1, 1'b0);
    push_samp(base + n + 1, ch, 1'b0, 1'b0);
    step(2);
  endtask

  // D=10 on ch0 with up to two loads, issued when cnt equals at_a / at_b.
  task automatic run_reload(input int at_a, input int va, input int at_b, input int vb,
                            input int t1, input int t2, input int t3, input int n);
    int base;
    load_idle(0, 10);
    bus.mode[0] = 1'b0;
    bus.en[0]   = 1'b1;
    base = cyc;
    push_tick(0, base + t1);
    push_tick(0, base + t2);
    push_tick(0, base + t3);
    step(at_a);
    bus.div_ld[0] = 1'b1;
    bus.div_in[0 +: CNT_W] = CNT_W'(va);
    step(1);
    bus.div_ld[0] = 1'b0;
    if (at_b > 0) begin
      step(at_b - at_a - 1);
      bus.div_ld[0] = 1'b1;
      bus.div_in[0 +: CNT_W] = CNT_W'(vb);
      step(1);
      bus.div_ld[0] = 1'b0;
    end
    step(n - (cyc - base));
    bus.en[0] = 1'b0;
    step(2);
  endtask

  initial begin
    int base;
    bus.en     = '0;
    bus.mode   = '0;
    bus.div_ld = '0;
    bus.div_in = '0;
    step(3);
    check("reset_tick", bus.tick, 0);
    check("reset_clk_out", bus.clk_out, 0);
    rst_n = 1'b1;
    step(1);

    // Default divisor 1000, tick mode.
    bus.en[0] = 1'b1;
    base = cyc;
    push_tick(0, base + 1000);
    push_tick(0, base + 2000);
    push_tick(0, base + 3000);
    push_samp(base + 999,  0, 1'b1, 1'b0);
    push_samp(base + 999,  0, 1'b0, 1'b0);
    push_samp(base + 1000, 0, 1'b1, 1'b1);
    push_samp(base + 1000, 0, 1'b0, 1'b1);
    push_samp(base + 1001, 0, 1'b1, 1'b0);
    push_samp(base + 1001, 0, 1'b0, 1'b0);
    step(3000);
    bus.en[0] = 1'b0;
    step(2);

    // Square patterns, counted from the tick cycle.
    run_ch(0, 5, 5, 1'b1, 8'b0000_0111, 15);
    run_ch(0, 4, 4, 1'b1, 8'b0000_0011, 12);
    run_ch(0, 1, 1, 1'b1, 8'b0000_0001, 4);
    run_ch(0, 0, 1, 1'b1, 8'b0000_0001, 4);
    run_ch(1, 6, 6, 1'b0, 8'b0000_0000, 12);

    // Shadowed reloads.
    run_reload(7, 3, -1, 0, 10, 13, 16, 17);
    run_reload(9, 3, -1, 0, 10, 13, 16, 17);
    run_reload(2, 7,  5, 2, 10, 12, 14, 15);

    // Enable drop at cnt=4, then restart.
    load_idle(0, 10);
    bus.mode[0] = 1'b1;
    bus.en[0]   = 1'b1;
    base = cyc;
    push_samp(base + 4, 0, 1'b1, 1'b1);
    push_samp(base + 5, 0, 1'b1, 1'b0);
    push_samp(base + 5, 0, 1'b0, 1'b0);
    step(4);
    bus.en[0] = 1'b0;
    step(3);
    bus.mode[0] = 1'b0;
    bus.en[0]   = 1'b1;
    base = cyc;
    push_tick(0, base + 10);
    push_samp(base + 9,  0, 1'b1, 1'b0);
    push_samp(base + 10, 0, 1'b1, 1'b1);
    step(12);
    bus.en[0] = 1'b0;
    step(2);

    // Asynchronous reset mid-period, between clock edges.
    load_idle(0, 10);
    bus.mode[0] = 1'b1;
    bus.en[0]   = 1'b1;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clk_out", bus.clk_out, 0);
    check("async_reset_tick", bus.tick, 0);
    bus.en = '0;
    step(1);
    rst_n = 1'b1;
    bus.mode[0] = 1'b0;
    bus.en[0]   = 1'b1;
    base = cyc;
    push_tick(0, base + DEF);
    step(DEF + 1);
    bus.en[0] = 1'b0;
    step(2);

    // Two channels concurrently: ch0 D=3 square, ch1 D=7 tick.
    bus.div_ld = 2'b11;
    bus.div_in = {16'd7, 16'd3};
    step(1);
    bus.div_ld = '0;
    bus.mode   = 2'b01;
    bus.en     = 2'b11;
    base = cyc;
    for (int k = 1; k <= 21; k++) begin
      if (k % 3 == 0) push_tick(0, base + k);
      if (k % 7 == 0) push_tick(1, base + k);
      push_samp(base + k, 0, 1'b1, (k % 3) < 2);
      push_samp(base + k, 1, 1'b1, (k % 7) == 0);
    end
    step(21);
    bus.en   = '0;
    bus.mode = '0;
    step(2);

`ifdef FDIV_TICKCNT_EN
    load_idle(0, 2);
    bus.en[0] = 1'b1;
    base = cyc;
    for (int k = 2; k <= 600; k += 2) push_tick(0, base + k);
    step(600);
    check("tick_cnt0_wrap", bus.tick_cnt[7:0], 44);
    check("tick_cnt1_idle", bus.tick_cnt[15:8], 0);
    bus.en[0] = 1'b0;
    step(1);
    check("tick_cnt0_clear", bus.tick_cnt[7:0], 0);
    step(2);
`endif

    step(5);
    check("tick0_queue_drained", tq0.size(), 0);
    check("tick1_queue_drained", tq1.size(), 0);
    check("sample_queue_drained", samp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
